// File: rtl/window_assemble.sv
// Assembles HEIGHT_NB x WIDTH_NB pixel windows from a column stream, never straddling rows.
// Latency 1 cycle up_val -> dn_val; valid-only stream, no backpressure.
module window_assemble #(
  parameter int HEIGHT_NB  = 3,
  parameter int WIDTH_NB   = 3,
  parameter int IMG_WIDTH  = 8,
  parameter int MEM_AWIDTH = 12
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic [MEM_AWIDTH-1:0]                   cfg_width,
  input  logic [MEM_AWIDTH-1:0]                   cfg_height,
  input  logic                                    cfg_set,
  input  logic [IMG_WIDTH*HEIGHT_NB-1:0]          up_data,
  input  logic                                    up_val,
  output logic [IMG_WIDTH*HEIGHT_NB*WIDTH_NB-1:0] dn_data,
  output logic                                    dn_val,
  output logic                                    dn_last,
  output logic                                    dn_frame
);

  localparam int COL_W  = IMG_WIDTH * HEIGHT_NB;
  localparam int WIN_W  = COL_W * WIDTH_NB;
  localparam int FILL_W = (WIDTH_NB > 1) ? $clog2(WIDTH_NB) : 1;
  localparam logic [FILL_W-1:0]     FILL_MAX = FILL_W'(WIDTH_NB - 1);
  localparam logic [FILL_W-1:0]     FILL_ONE = FILL_W'(1);
  localparam logic [MEM_AWIDTH-1:0] H_AW     = MEM_AWIDTH'(HEIGHT_NB);
  localparam logic [MEM_AWIDTH-1:0] ONE      = MEM_AWIDTH'(1);

  logic [MEM_AWIDTH-1:0] cfg_w_q;
  logic [MEM_AWIDTH-1:0] cfg_h_q;
  logic [MEM_AWIDTH-1:0] x_q;
  logic [MEM_AWIDTH-1:0] y_q;
  logic [FILL_W-1:0]     fill_q;
  logic [WIN_W-1:0]      win_nxt;
  logic                  win_ok;
  logic                  row_end;
  logic                  frame_ok;
  logic                  frame_row;

  // dn_data doubles as the column shift register: it only moves on an accepted column.
  generate
    if (WIDTH_NB > 1) begin : g_shift
      assign win_nxt = {dn_data[WIN_W-COL_W-1:0], up_data};
    end else begin : g_single
      assign win_nxt = up_data;
    end
  endgenerate

  assign win_ok    = (fill_q == FILL_MAX);
  assign row_end   = (x_q == cfg_w_q - ONE);
  assign frame_ok  = (cfg_h_q >= H_AW);
  assign frame_row = frame_ok && (y_q == cfg_h_q - H_AW);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_w_q  <= '0;
      cfg_h_q  <= '0;
      x_q      <= '0;
      y_q      <= '0;
      fill_q   <= '0;
      dn_data  <= '0;
      dn_val   <= 1'b0;
      dn_last  <= 1'b0;
      dn_frame <= 1'b0;
    end else if (cfg_set) begin
      // A column arriving alongside cfg_set is intentionally dropped.
      cfg_w_q  <= cfg_width;
      cfg_h_q  <= cfg_height;
      x_q      <= '0;
      y_q      <= '0;
      fill_q   <= '0;
      dn_val   <= 1'b0;
      dn_last  <= 1'b0;
      dn_frame <= 1'b0;
    end else if (up_val) begin
      dn_data  <= win_nxt;
      dn_val   <= win_ok;
      dn_last  <= win_ok && row_end;
      dn_frame <= win_ok && row_end && frame_row;
      if (row_end) begin
        x_q    <= '0;
        fill_q <= '0;
        y_q    <= frame_row ? '0 : y_q + ONE;
      end else begin
        x_q <= x_q + ONE;
        if (!win_ok) fill_q <= fill_q + FILL_ONE;
      end
    end else begin
      dn_val   <= 1'b0;
      dn_last  <= 1'b0;
      dn_frame <= 1'b0;
    end
  end

endmodule

// File: doc/window_assemble.md
Name: window_assemble

Overview:
- Downstream end of the line-delay column stream: consumes the HEIGHT_NB-pixel vertical column emitted each valid cycle and assembles a HEIGHT_NB x WIDTH_NB pixel window for the filter core.
- Keeps a column shift register plus column/row counters, so windows are emitted only once fully populated within a row.
- Flags the last window of each row and of each frame.
- Valid-only stream with no backpressure, matching the column source.

Parameters:
HEIGHT_NB, 3, rows per window (pixels per input column)
WIDTH_NB, 3, columns per window (must be >= 1)
IMG_WIDTH, 8, bits per pixel
MEM_AWIDTH, 12, width of the cfg_width/cfg_height counters

Ports:
clk  input  1  clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
cfg_width  input  MEM_AWIDTH  image width in pixels (columns per row)
cfg_height  input  MEM_AWIDTH  image height in pixels
cfg_set  input  1  latch cfg_width/cfg_height and restart the frame
up_data  input  IMG_WIDTH*HEIGHT_NB  column; slice h is row h, h=0 newest row
up_val  input  1  column valid
dn_data  output  IMG_WIDTH*HEIGHT_NB*WIDTH_NB  window; pixel (w,h) at [(w*HEIGHT_NB+h)*IMG_WIDTH +: IMG_WIDTH], w=0 newest column
dn_val  output  1  window valid, single-cycle per window
dn_last  output  1  qualifies dn_val: last window of a row
dn_frame  output  1  qualifies dn_val: last window of the frame

Behaviour:
- Reset (rst_n low, asynchronous):
  - dn_val, dn_last and dn_frame go to 0.
  - Column and row counters, the fill counter and the latched cfg registers clear.
  - dn_data clears to 0.
- cfg_set:
  - Registers cfg_width/cfg_height.
  - Clears x (column), y (row) and fill counters.
  - Takes effect the next cycle.
  - An up_val in the same cycle as cfg_set is dropped.
  - dn_val is 0 the cycle after cfg_set.
- Column shift on up_val=1:
  - column w moves to w+1 for w=0..WIDTH_NB-2.
  - up_data is loaded into column 0.
  - The oldest column is discarded.
  - On up_val=0, all state holds.
- Fill counter:
  - Increments on up_val and saturates at WIDTH_NB-1.
  - Clears when x wraps.
  - Windows never straddle rows.
- Window valid: dn_val=1 the cycle after an up_val for which fill (before increment) >= WIDTH_NB-1.
  - Latency is 1 cycle, up_val to dn_val.
  - dn_data is registered and changes only on up_val.
- x counter:
  - Counts accepted columns 0..cfg_width-1.
  - On the accept with x==cfg_width-1: x wraps to 0, fill clears, and y increments.
  - dn_last=1 accompanies that window, provided it is valid.
- y counter:
  - Counts window rows 0..cfg_height-HEIGHT_NB.
  - The row-wrap accept with y==cfg_height-HEIGHT_NB asserts dn_frame alongside dn_last.
  - y then returns to 0, ready for the next frame without cfg_set.
- Width/height edge cases:
  - cfg_width < WIDTH_NB: no window is ever valid. x still wraps, and dn_last/dn_frame are never asserted.
  - cfg_height < HEIGHT_NB: dn_frame is never asserted. Windows are still produced.
- The counters are MEM_AWIDTH bits. Comparisons are unsigned and use the latched cfg values only.
- Back-to-back up_val on every cycle is fully supported: one window per cycle once filled.
- Gaps in up_val do not break window adjacency; columns are counted, not cycles.
- Reset mid-frame: all state is lost. The next accepted column is treated as column 0 of row 0 with the cfg registers cleared, so software must reissue cfg_set.

Test Plan:
- Reset: hold rst_n low while up_val toggles -> dn_val, dn_last and dn_frame stay 0 and dn_data is 0; on release, no output until cfg_set plus columns.
- Row fill, W=3 H=3, cfg_width=5: feed columns with row0 values 1..5 -> dn_val on the 3rd, 4th and 5th columns.
  - The first window has w0=3, w1=2, w2=1.
  - dn_last is asserted only with the 5th column's window.
- Row wrap: continue with columns 6..10 as the next row -> there is no window on 6 or 7; the first window of the row is (8,7,6). Adjacency across the row boundary is never emitted.
- Frame end, cfg_width=4, cfg_height=4, H=3: two window rows of 2 windows each -> dn_frame on the 4th window together with dn_last; the next column restarts at x=0, y=0.
- Gapped input: insert random up_val=0 bubbles into the row-fill stream -> identical window sequence and flags, each window 1 cycle after its column.
- Edge/config cases:
  - cfg_width=2 with W=3 -> dn_val never asserts across 3 rows.
  - cfg_set mid-row with concurrent up_val -> that column is dropped, and the next window requires 3 fresh columns.
